// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: default pipeline
// depth, stage index names, stall bus width and the flush FSM encoding.
package pipe_hazard_ctrl_pkg;

    // Default number of stall-vector bits (PC plus five pipeline stages).
    localparam int STAGES_DEF = 6;

    // Width of the stall bus for the default pipeline.
    localparam int STALL_W = STAGES_DEF;

    // Stage indices as used on stall_stage / timed_stage.
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Flush sequencing FSM.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of request and control signals between the pipeline stages
// (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STAGES  = STAGES_DEF,
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 6,
    parameter int STAGE_W = $clog2(STAGES)
);
    // Signalling: there is no valid/ready pair here. stall_req is a level
    // request honoured in the same cycle; timed_start and flush_req are
    // sampled at each rising edge and are never back-pressured (a request
    // that loses on priority or arrives while busy is simply dropped).
    logic [NUM_REQ-1:0]         stall_req;
    logic [NUM_REQ*STAGE_W-1:0] stall_stage;
    logic                       timed_start;
    logic [STAGE_W-1:0]         timed_stage;
    logic [CNT_W-1:0]           timed_len;
    logic                       flush_req;
    logic [31:0]                flush_pc;
    logic                       flush;
    logic [31:0]                new_pc;
    logic [STAGES-1:0]          stall;
    logic                       busy;
    logic [31:0]                stall_cycles;
    hz_state_e                  dbg_state;

    modport master (
        output stall_req, stall_stage, timed_start, timed_stage, timed_len,
               flush_req, flush_pc,
        input  flush, new_pc, stall, busy, stall_cycles, dbg_state
    );

    modport slave (
        input  stall_req, stall_stage, timed_start, timed_stage, timed_len,
               flush_req, flush_pc,
        output flush, new_pc, stall, busy, stall_cycles, dbg_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_stall_mask_gen.sv
// Index-to-thermometer mask: bit k is set for every k <= idx_i, so an index
// at or beyond the last stage saturates to all ones.
module stall_mask_gen #(
    parameter int STAGES  = 6,
    parameter int STAGE_W = $clog2(STAGES)
) (
    input  logic [STAGE_W-1:0] idx_i,
    output logic [STAGES-1:0]  mask_o
);

    // Thermometer decode of the stage index.
    always_comb begin
        mask_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            mask_o[k] = (32'(idx_i) >= k);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges level stall requests, runs one timed
// stall for multi-cycle units, and sequences registered flush/redirect.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STAGES       = STAGES_DEF,
    parameter int NUM_REQ      = 2,
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int STAGE_W      = $clog2(STAGES)
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    hz_state_e                 state_q, state_d;
    logic                      flush_q, flush_d;
    logic [31:0]               pc_q, pc_d;
    logic [FC_W-1:0]           fcnt_q, fcnt_d;
    logic                      busy_q, busy_d;
    logic [CNT_W-1:0]          tcnt_q, tcnt_d;
    logic [STAGES-1:0]         tmask_q, tmask_d;
    logic [31:0]               sc_q, sc_d;

    logic [NUM_REQ*STAGES-1:0] req_masks;
    logic [STAGES-1:0]         timed_mask_new;
    logic [STAGES-1:0]         level_mask;
    logic [STAGES-1:0]         stall_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_mask
        stall_mask_gen #(.STAGES(STAGES), .STAGE_W(STAGE_W)) u_req_mask (
            .idx_i  (bus.stall_stage[g*STAGE_W +: STAGE_W]),
            .mask_o (req_masks[g*STAGES +: STAGES])
        );
    end

    stall_mask_gen #(.STAGES(STAGES), .STAGE_W(STAGE_W)) u_timed_mask (
        .idx_i  (bus.timed_stage),
        .mask_o (timed_mask_new)
    );

    // OR together the masks of all sources currently requesting a stall.
    always_comb begin
        level_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.stall_req[i]) begin
                level_mask = level_mask | req_masks[i*STAGES +: STAGES];
            end
        end
    end

    // Final stall vector; a flush overrides every stall so the pipe can drain.
    always_comb begin
        stall_c = level_mask | (busy_q ? tmask_q : '0);
        if (rst || (state_q == ST_FLUSH)) begin
            stall_c = '0;
        end
    end

    // Next-state logic for the flush FSM, timed stall and stall statistics.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        pc_d    = pc_q;
        fcnt_d  = fcnt_q;
        busy_d  = busy_q;
        tcnt_d  = tcnt_q;
        tmask_d = tmask_q;
        sc_d    = sc_q;

        if ((stall_c != '0) && (sc_q != 32'hFFFF_FFFF)) begin
            sc_d = sc_q + 32'd1;
        end

        if (busy_q) begin
            tcnt_d = tcnt_q - CNT_W'(1);
            busy_d = (tcnt_q != CNT_W'(1));
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b1;
                    pc_d    = bus.flush_pc;
                    fcnt_d  = FLUSH_RELOAD;
                    tcnt_d  = '0;
                    busy_d  = 1'b0;
                end else if (bus.timed_start && !busy_q && (bus.timed_len != '0)) begin
                    tmask_d = timed_mask_new;
                    tcnt_d  = bus.timed_len;
                    busy_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (bus.flush_req) begin
                    pc_d   = bus.flush_pc;
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                    pc_d    = '0;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
            pc_q    <= '0;
            fcnt_q  <= '0;
            busy_q  <= 1'b0;
            tcnt_q  <= '0;
            tmask_q <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= busy_d;
            tcnt_q  <= tcnt_d;
            tmask_q <= tmask_d;
            sc_q    <= sc_d;
        end
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_q;
    assign bus.new_pc       = pc_q;
    assign bus.busy         = busy_q;
    assign bus.stall_cycles = sc_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (STAGES=6, NUM_REQ=2, FLUSH_CYCLES=2).
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    pipe_hazard_ctrl_if #(.STAGES(6), .NUM_REQ(2), .CNT_W(6), .STAGE_W(3)) bus ();

    pipe_hazard_ctrl #(
        .STAGES(6), .NUM_REQ(2), .CNT_W(6), .FLUSH_CYCLES(2), .STAGE_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall_req = 2'b11;
        bus.stall_stage = {3'd5, 3'd5};
        step();
        step();
        vectors++;
        if (bus.stall !== 6'b000000) begin miscompares++; $display("FAIL reset_stall: got %b want 000000", bus.stall); end
        vectors++;
        if (bus.flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        vectors++;
        if (bus.new_pc !== 32'h0) begin miscompares++; $display("FAIL reset_new_pc: got %h want 0", bus.new_pc); end
        vectors++;
        if (bus.stall_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        bus.stall_req = 2'b00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_level();
        bus.stall_req = 2'b11;
        bus.stall_stage = {3'd2, 3'd0};
        #1;
        vectors++;
        if (bus.stall !== 6'b000111) begin miscompares++; $display("FAIL level_0_2: got %b want 000111", bus.stall); end
        bus.stall_req = 2'b01;
        bus.stall_stage = {3'd0, 3'd7};
        #1;
        vectors++;
        if (bus.stall !== 6'b111111) begin miscompares++; $display("FAIL level_idx7: got %b want 111111", bus.stall); end
        bus.stall_req = 2'b10;
        bus.stall_stage = {3'd3, 3'd7};
        #1;
        vectors++;
        if (bus.stall !== 6'b001111) begin miscompares++; $display("FAIL level_src1_3: got %b want 001111", bus.stall); end
        bus.stall_req = 2'b11;
        bus.stall_stage = {3'd4, 3'd1};
        #1;
        vectors++;
        if (bus.stall !== 6'b011111) begin miscompares++; $display("FAIL level_1_4: got %b want 011111", bus.stall); end
        bus.stall_req = 2'b00;
        #1;
        vectors++;
        if (bus.stall !== 6'b000000) begin miscompares++; $display("FAIL level_none: got %b want 000000", bus.stall); end
        // One stalled edge should count once.
        bus.stall_req = 2'b01;
        bus.stall_stage = {3'd0, 3'd0};
        step();
        bus.stall_req = 2'b00;
        vectors++;
        if (bus.stall_cycles !== 32'd1) begin miscompares++; $display("FAIL level_count: got %0d want 1", bus.stall_cycles); end
    endtask

    task automatic test_timed();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.timed_start = 1'b1;
        bus.timed_stage = 3'd3;
        bus.timed_len = 6'd4;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.stall !== 6'b000000) begin
            miscompares++; $display("FAIL timed_pre: got busy=%b stall=%b want busy=0 stall=000000", bus.busy, bus.stall);
        end
        step();
        bus.timed_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (bus.stall !== 6'b001111) begin miscompares++; $display("FAIL timed_stall_t%0d: got %b want 001111", i, bus.stall); end
            vectors++;
            if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL timed_busy_t%0d: got %b want 1", i, bus.busy); end
            if (i == 2) begin
                bus.timed_start = 1'b1;
                bus.timed_stage = 3'd5;
                bus.timed_len = 6'd9;
            end else begin
                bus.timed_start = 1'b0;
            end
            step();
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.stall !== 6'b000000) begin
            miscompares++; $display("FAIL timed_end: got busy=%b stall=%b want busy=0 stall=000000", bus.busy, bus.stall);
        end
        vectors++;
        if (bus.stall_cycles !== 32'd4) begin miscompares++; $display("FAIL timed_count: got %0d want 4", bus.stall_cycles); end
        // Zero-length request is ignored.
        bus.timed_start = 1'b1;
        bus.timed_stage = 3'd2;
        bus.timed_len = 6'd0;
        step();
        bus.timed_start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.stall !== 6'b000000) begin
            miscompares++; $display("FAIL timed_len0: got busy=%b stall=%b want busy=0 stall=000000", bus.busy, bus.stall);
        end
    endtask

    task automatic test_flush();
        bus.timed_start = 1'b1;
        bus.timed_stage = 3'd2;
        bus.timed_len = 6'd10;
        step();
        bus.timed_start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.stall !== 6'b000111) begin
            miscompares++; $display("FAIL flush_pre_timed: got busy=%b stall=%b want busy=1 stall=000111", bus.busy, bus.stall);
        end
        bus.flush_req = 1'b1;
        bus.flush_pc = 32'hBFC00380;
        step();
        bus.flush_req = 1'b0;
        vectors++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'hBFC00380) begin
            miscompares++; $display("FAIL flush_c1: got flush=%b pc=%h want flush=1 pc=bfc00380", bus.flush, bus.new_pc);
        end
        vectors++;
        if (bus.stall !== 6'b000000 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_c1_stall: got stall=%b busy=%b want stall=000000 busy=0", bus.stall, bus.busy);
        end
        vectors++;
        if (bus.dbg_state !== ST_FLUSH) begin miscompares++; $display("FAIL flush_state: got %0d want 1", bus.dbg_state); end
        bus.stall_req = 2'b01;
        bus.stall_stage = {3'd0, 3'd4};
        #1;
        vectors++;
        if (bus.stall !== 6'b000000) begin miscompares++; $display("FAIL flush_level_masked: got %b want 000000", bus.stall); end
        bus.stall_req = 2'b00;
        step();
        vectors++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'hBFC00380 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_c2: got flush=%b pc=%h busy=%b want flush=1 pc=bfc00380 busy=0", bus.flush, bus.new_pc, bus.busy);
        end
        step();
        vectors++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0 || bus.busy !== 1'b0 || bus.stall !== 6'b000000) begin
            miscompares++; $display("FAIL flush_done: got flush=%b pc=%h busy=%b stall=%b want 0/0/0/000000", bus.flush, bus.new_pc, bus.busy, bus.stall);
        end
    endtask

    task automatic test_back_to_back();
        bus.flush_req = 1'b1;
        bus.flush_pc = 32'h0000_1000;
        step();
        vectors++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0000_1000) begin
            miscompares++; $display("FAIL b2b_a: got flush=%b pc=%h want flush=1 pc=00001000", bus.flush, bus.new_pc);
        end
        bus.flush_pc = 32'h0000_2000;
        step();
        bus.flush_req = 1'b0;
        // A timed start during FLUSH must be discarded.
        bus.timed_start = 1'b1;
        bus.timed_stage = 3'd3;
        bus.timed_len = 6'd2;
        vectors++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0000_2000) begin
            miscompares++; $display("FAIL b2b_b1: got flush=%b pc=%h want flush=1 pc=00002000", bus.flush, bus.new_pc);
        end
        step();
        bus.timed_start = 1'b0;
        vectors++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0000_2000 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL b2b_b2: got flush=%b pc=%h busy=%b want flush=1 pc=00002000 busy=0", bus.flush, bus.new_pc, bus.busy);
        end
        step();
        vectors++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL b2b_done: got flush=%b pc=%h busy=%b want 0/0/0", bus.flush, bus.new_pc, bus.busy);
        end
    endtask

    task automatic test_simultaneous();
        bus.flush_req = 1'b1;
        bus.flush_pc = 32'h0000_3000;
        bus.timed_start = 1'b1;
        bus.timed_stage = 3'd1;
        bus.timed_len = 6'd3;
        step();
        bus.flush_req = 1'b0;
        bus.timed_start = 1'b0;
        vectors++;
        if (bus.flush !== 1'b1 || bus.new_pc !== 32'h0000_3000 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL simul_take: got flush=%b pc=%h busy=%b want flush=1 pc=00003000 busy=0", bus.flush, bus.new_pc, bus.busy);
        end
        rst = 1'b1;
        bus.stall_req = 2'b11;
        #1;
        vectors++;
        if (bus.stall !== 6'b000000) begin miscompares++; $display("FAIL rst_stall_forced: got %b want 000000", bus.stall); end
        step();
        vectors++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_flush: got flush=%b pc=%h busy=%b want 0/0/0", bus.flush, bus.new_pc, bus.busy);
        end
        vectors++;
        if (bus.dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want 0", bus.dbg_state); end
        bus.stall_req = 2'b00;
        rst = 1'b0;
        step();
    endtask

    initial begin
        bus.stall_req = '0;
        bus.stall_stage = '0;
        bus.timed_start = 1'b0;
        bus.timed_stage = '0;
        bus.timed_len = '0;
        bus.flush_req = 1'b0;
        bus.flush_pc = '0;
        test_reset();
        test_level();
        test_timed();
        test_flush();
        test_back_to_back();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
